// File: rtl/program_loader.sv
// Byte-stream program loader: assembles 16-bit words from a framed byte stream,
// writes them into instruction RAM and holds the CPU in reset until a good checksum.
module program_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [6:0]        words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WR,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   din;
  logic [7:0]          hi;
  logic [7:0]          chk;
  logic [6:0]          count;
  logic [6:0]          wl;

  logic accept;
  logic len_bad;
  logic last_word;

  // in_ready is a pure state decode, so accept never depends combinationally on itself
  assign accept    = in_valid && in_ready;
  assign len_bad   = (in_data == '0) || (in_data > DEPTH_B);
  assign last_word = (wl + 7'd1) == count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_LEN;
      S_LEN:   if (accept) state_next = len_bad ? S_ERR : S_HI;
      S_HI:    if (accept) state_next = S_LO;
      S_LO:    if (accept) state_next = S_WR;
      S_WR:    state_next = last_word ? S_CHK : S_HI;
      S_CHK:   if (accept) state_next = (in_data == chk) ? S_DONE : S_ERR;
      S_DONE:  if (start) state_next = S_LEN;
      S_ERR:   if (start) state_next = S_LEN;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    ram_we   = 1'b0;
    cpu_rst  = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state)
      S_LEN, S_HI, S_LO, S_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WR: begin
        ram_we = 1'b1;
        busy   = 1'b1;
      end
      S_DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  // Address advances only when another word follows, so it holds N-1 after the load
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      din   <= '0;
      hi    <= '0;
      chk   <= '0;
      count <= '0;
      wl    <= '0;
    end else begin
      unique case (state)
        S_LEN: begin
          if (accept && !len_bad) begin
            count <= in_data[6:0];
            addr  <= '0;
            chk   <= '0;
            wl    <= '0;
          end
        end
        S_HI: begin
          if (accept) begin
            hi  <= in_data;
            chk <= chk ^ in_data;
          end
        end
        S_LO: begin
          if (accept) begin
            din <= DATA_W'({hi, in_data});
            chk <= chk ^ in_data;
          end
        end
        S_WR: begin
          wl <= wl + 7'd1;
          if (!last_word) addr <= addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ram_addr     = addr;
  assign ram_din      = din;
  assign words_loaded = wl;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framed loads, checksum errors, length limits,
// stalls, mid-load reset and reload from DONE.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [15:0] ram_din;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [6:0]  words_loaded;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [5:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  logic        gaps = 1'b0;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(6), .DEPTH(64), .DATA_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  // ram_we lasts one full cycle, so the falling edge sees each write exactly once
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_din);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("rdy_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] c;
    logic [7:0] h;
    logic [7:0] l;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_ram_din", 32'(ram_din), 32'd0);
    check_eq("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: three-word good load
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check_eq("t1_busy", 32'(busy), 32'd1);
    fr = '{8'h03, 8'h12, 8'h34, 8'hC0, 8'h05, 8'h00, 8'h00, 8'hE3};
    send_frame(fr);
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_cpu_rst", 32'(cpu_rst), 32'd0);
    check_eq("t1_words", 32'(words_loaded), 32'd3);
    check_eq("t1_nwr", wr_addr.size(), 32'd3);
    check_eq("t1_a0", 32'(wr_addr[0]), 32'd0);
    check_eq("t1_a1", 32'(wr_addr[1]), 32'd1);
    check_eq("t1_a2", 32'(wr_addr[2]), 32'd2);
    check_eq("t1_d0", 32'(wr_data[0]), 32'h1234);
    check_eq("t1_d1", 32'(wr_data[1]), 32'hC005);
    check_eq("t1_d2", 32'(wr_data[2]), 32'h0000);
    check_eq("t1_hold_addr", 32'(ram_addr), 32'd2);
    check_eq("t1_busy_end", 32'(busy), 32'd0);

    // 2: restart from DONE, bad checksum
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check_eq("t2_cpu_rst_up", 32'(cpu_rst), 32'd1);
    check_eq("t2_busy", 32'(busy), 32'd1);
    check_eq("t2_done_clr", 32'(done), 32'd0);
    fr = '{8'h03, 8'h12, 8'h34, 8'hC0, 8'h05, 8'h00, 8'h00, 8'hE2};
    send_frame(fr);
    check_eq("t2_nwr", wr_addr.size(), 32'd3);
    check_eq("t2_error", 32'(error), 32'd1);
    check_eq("t2_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("t2_done", 32'(done), 32'd0);

    // 3: out-of-range lengths
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h00);
    check_eq("t3_len0_err", 32'(error), 32'd1);
    check_eq("t3_len0_rdy", 32'(in_ready), 32'd0);
    pulse_start();
    check_eq("t3_err_clr", 32'(error), 32'd0);
    send_byte(8'h41);
    check_eq("t3_len65_err", 32'(error), 32'd1);
    check_eq("t3_nwr", wr_addr.size(), 32'd0);

    // 4: maximum-length load
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    fr = '{8'h40};
    c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      h = 8'(i);
      l = 8'hFF - 8'(i);
      fr.push_back(h);
      fr.push_back(l);
      c = c ^ h ^ l;
    end
    fr.push_back(c);
    send_frame(fr);
    check_eq("t4_done", 32'(done), 32'd1);
    check_eq("t4_words", 32'(words_loaded), 32'd64);
    check_eq("t4_nwr", wr_addr.size(), 32'd64);
    for (int i = 0; i < 64; i++) begin
      check_eq("t4_addr", 32'(wr_addr[i]), 32'(i));
      check_eq("t4_data", 32'(wr_data[i]), {16'h0, 8'(i), 8'hFF - 8'(i)});
    end
    check_eq("t4_last_addr", 32'(ram_addr), 32'd63);
    check_eq("t4_last_din", 32'(ram_din), 32'h3FC0);

    // 5: stalled stream, reset after two words
    wr_addr.delete(); wr_data.delete();
    gaps = 1'b1;
    pulse_start();
    fr = '{8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    send_frame(fr);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("t5_ram_we", 32'(ram_we), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_words", 32'(words_loaded), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (5) @(negedge clk);
    check_eq("t5_idle_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    check_eq("t5_nwr", wr_addr.size(), 32'd2);
    check_eq("t5_d0", 32'(wr_data[0]), 32'hA1B2);
    check_eq("t5_d1", 32'(wr_data[1]), 32'hC3D4);
    gaps = 1'b0;

    // 6: good load, reload from DONE with a stray start mid-frame
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    fr = '{8'h01, 8'hAB, 8'hCD, 8'h66};
    send_frame(fr);
    check_eq("t6_done1", 32'(done), 32'd1);
    pulse_start();
    check_eq("t6_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("t6_busy", 32'(busy), 32'd1);
    send_byte(8'h02);
    send_byte(8'h11);
    pulse_start();
    fr = '{8'h22, 8'h33, 8'h44, 8'h44};
    send_frame(fr);
    check_eq("t6_done2", 32'(done), 32'd1);
    check_eq("t6_cpu_rst2", 32'(cpu_rst), 32'd0);
    check_eq("t6_words", 32'(words_loaded), 32'd2);
    check_eq("t6_nwr", wr_addr.size(), 32'd3);
    check_eq("t6_d2", 32'(wr_data[2]), 32'h3344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
